qupls_ins_window: RTL and testbench
===================================

# qupls_ins_window

Instruction window builder feeding the Qupls decoder. It accepts fetch beats of FETCH_W instructions into a circular instruction queue. It presents the decoder with a six-slot window: the head instruction plus the instructions that follow it. Slots 1..5 carry any postfix immediates belonging to the head. On decoder acceptance it retires the head together with its postfixes, and it absorbs REX prefixes into a register-extension value.

## Interface
- DEPTH, 16: queue entries; power of two, ≥ FETCH_W+6.
- FETCH_W, 4: instructions per fetch beat.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous queue clear (branch miss, exception).
- fetch_v  in  1  fetch beat valid.
- fetch_rdy  out  1  queue can take a beat.
- fetch_ins  in  FETCH_W×instruction_t  instructions; slot 0 is lowest address.
- fetch_pc  in  address_t  address of fetch_ins[0].
- win_v  out  1  window valid (complete instruction group at head).
- win_rdy  in  1  decoder accepts window (decoder enable).
- win_ins  out  6×instruction_t  window; slot 0 is the head; slots beyond win_len hold NOP_INSN.
- win_pc  out  address_t  address of the head.
- win_len  out  3  1..6, head plus postfix count.
- regx  out  4  register-extension bits for the windowed instruction.

## Operation
- Queue: entries {instruction_t, address_t}; head, tail and count registers.
  - Entry i of a beat gets pc = fetch_pc + i·INSN_BYTES.
- Push: when fetch_v && fetch_rdy, write FETCH_W entries at tail.
  - tail += FETCH_W; head and tail wrap modulo DEPTH.
  - fetch_rdy = (count ≤ DEPTH−FETCH_W), from registered count only.
- Postfix scan: for k = 1..5, slot k is a postfix iff k < count, q[head+k] opcode == OP_PFX, and all slots 1..k−1 were postfixes.
  - npfx = number of postfix slots.
  - The window is incomplete when the scan runs out of present entries (k == count, k ≤ 5) while all earlier slots were postfixes.
  - Incomplete: win_v = 0, wait for more fetch.
- Head classification, evaluated when count > 0:
  - OP_PFX at head (orphan): dropped. head += 1 with win_v = 0.
  - OP_REX at head (see Configuration): absorbed. head += 1 with win_v = 0.
  - Otherwise: win_v = 1 if the window is complete; win_len = 1 + npfx.
- Pop: on win_v && win_rdy, head += win_len and count −= win_len.
- Simultaneous push and pop: count_next = count + FETCH_W − popped; both pointers update in the same cycle.
- Flush has priority over push, pop, drop and absorb. Next cycle: head = tail = count = 0, regx_r = 0, win_v = 0. A fetch beat presented in the flush cycle is discarded.
- Count arithmetic uses log2(DEPTH)+1 bits. Overflow cannot occur because of the fetch_rdy gating.

## Timing
- Reset values: head, tail, count = 0; win_v = 0; fetch_rdy = 1; win_len = 1; win_ins = NOP_INSN ×6; win_pc = 0; regx = 0.
- Latency: a beat accepted at edge N appears at win_v in cycle N+1.
- Window outputs derive combinationally from registered queue state only. There is no combinational path from win_rdy or fetch_v to any output.
- win_v stays asserted and win_ins stays stable until win_rdy is sampled high.
- Drops and absorbs: one per cycle, only in cycles with win_v = 0.
- Reset asserted mid-operation clears everything immediately (asynchronous); the queue contents are don't-care.

## Configuration
- QUPLS_REX_EN defined:
  - A head with opcode OP_REX loads regx_r <= ins[REX_LSB+3:REX_LSB] and is absorbed.
  - A later REX overwrites regx_r.
  - regx = regx_r while win_v; regx_r clears on pop.
- QUPLS_REX_EN undefined: OP_REX is windowed as an ordinary instruction; regx is tied to 0.

## Structure
- QuplsPkg additions: OP_PFX, OP_REX, NOP_INSN, INSN_BYTES, REX_LSB.
- Sub-module qupls_pfx_scan: combinational; inputs are six instructions plus an available-count; outputs are npfx and complete.

## Test plan
- Beat {ADD, ADD, ADD, ADD} at pc 0x100, win_rdy = 1 → four windows on consecutive cycles, win_len = 1, win_pc 0x100/0x105/0x10A/0x10F.
- Beat {LDI, PFX, PFX, ADD} → first window win_len = 3 with slots 1–2 = PFX and slots 3–5 = NOP_INSN; next window ADD at +15.
- Beat {X, X, LDI, PFX}, then the next beat {PFX, PFX, ADD, ADD} delayed 3 cycles → LDI is withheld (win_v = 0) until that beat arrives, then win_len = 4.
- Fill to 16 entries with win_rdy = 0 → fetch_rdy = 0 at count 13..16. Release win_rdy → push and pop in the same cycle with the correct count; head wraps 15→0 correctly.
- Flush asserted together with fetch_v and win_rdy → next cycle count = 0, win_v = 0; the beat is discarded.
- With QUPLS_REX_EN: REX(regx = 4'b1010) followed by ADD → one cycle with win_v = 0, then ADD with regx = 4'b1010; the next window has regx = 0. Without the macro, REX is windowed and regx = 0.

Source files
------------

// File: rtl/qupls_ins_window_pkg.sv
// Shared types and constants for the Qupls instruction window builder.
// Instruction format: 40-bit words, opcode in bits [6:0].
package qupls_ins_window_pkg;

    localparam int unsigned INSN_W     = 40;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned INSN_BYTES = 5;
    localparam int unsigned REX_LSB    = 7;

    typedef logic [INSN_W-1:0] instruction_t;
    typedef logic [ADDR_W-1:0] address_t;

    typedef struct packed {
        instruction_t ins;
        address_t     pc;
    } q_entry_t;

    localparam logic [6:0] OP_ADD = 7'h04;
    localparam logic [6:0] OP_SUB = 7'h05;
    localparam logic [6:0] OP_LDI = 7'h09;
    localparam logic [6:0] OP_NOP = 7'h0B;
    localparam logic [6:0] OP_REX = 7'h7D;
    localparam logic [6:0] OP_PFX = 7'h7E;

    localparam instruction_t NOP_INSN = {{(INSN_W-7){1'b0}}, OP_NOP};

    function automatic logic [6:0] opcode_of(input instruction_t i);
        return i[6:0];
    endfunction

endpackage

// File: rtl/qupls_ins_window_pfx_scan.sv
// Postfix scanner: counts the run of OP_PFX slots following the head and
// reports whether that run is known to be terminated within the present entries.
module qupls_pfx_scan
    import qupls_ins_window_pkg::*;
(
    input  instruction_t [5:0] ins,
    input  logic [2:0]         avail,
    output logic [2:0]         npfx,
    output logic               complete
);

    // Only opcodes of slots 1..5 steer the scan.
    logic unused_ins;
    assign unused_ins = ^ins;

    always_comb begin
        logic run;
        npfx     = '0;
        complete = 1'b1;
        run      = 1'b1;
        for (int unsigned k = 1; k < 6; k++) begin
            if (run) begin
                if (3'(k) >= avail) begin
                    complete = 1'b0;
                    run      = 1'b0;
                end else if (opcode_of(ins[k]) == OP_PFX) begin
                    npfx = npfx + 3'd1;
                end else begin
                    run = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/qupls_ins_window.sv
// Circular instruction queue presenting a head-plus-postfix window to the decoder.
// Optional REX absorption into regx is enabled by defining QUPLS_REX_EN.
module qupls_ins_window
    import qupls_ins_window_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned FETCH_W = 4
)
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        fetch_v,
    output logic                        fetch_rdy,
    input  instruction_t [FETCH_W-1:0]  fetch_ins,
    input  address_t                    fetch_pc,
    output logic                        win_v,
    input  logic                        win_rdy,
    output instruction_t [5:0]          win_ins,
    output address_t                    win_pc,
    output logic [2:0]                  win_len,
    output logic [3:0]                  regx
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {HEAD_EMPTY, HEAD_DROP, HEAD_ABSORB, HEAD_INSN} head_kind_t;

    q_entry_t           q [DEPTH];
    logic [PTR_W-1:0]   head, tail;
    logic [CNT_W-1:0]   count, adv;
    instruction_t [5:0] slot;
    logic [2:0]         avail, npfx;
    logic               complete, push, pop;
    head_kind_t         head_kind;

    always_comb begin
        for (int unsigned k = 0; k < 6; k++) begin
            slot[k] = q[head + PTR_W'(k)].ins;
        end
    end

    assign avail = (count >= CNT_W'(6)) ? 3'd6 : count[2:0];

    qupls_pfx_scan u_scan (
        .ins      (slot),
        .avail    (avail),
        .npfx     (npfx),
        .complete (complete)
    );

    always_comb begin
        head_kind = HEAD_EMPTY;
        if (count != '0) begin
            if (opcode_of(slot[0]) == OP_PFX)
                head_kind = HEAD_DROP;
`ifdef QUPLS_REX_EN
            else if (opcode_of(slot[0]) == OP_REX)
                head_kind = HEAD_ABSORB;
`endif
            else
                head_kind = HEAD_INSN;
        end
    end

    assign fetch_rdy = (count <= CNT_W'(DEPTH - FETCH_W));
    assign win_v     = (head_kind == HEAD_INSN) && complete;
    assign push      = fetch_v && fetch_rdy && !flush;
    assign pop       = win_v && win_rdy;

    always_comb begin
        adv = '0;
        if (pop)
            adv = CNT_W'(npfx) + CNT_W'(1);
        else if (head_kind == HEAD_DROP || head_kind == HEAD_ABSORB)
            adv = CNT_W'(1);
    end

    always_comb begin
        win_len = 3'd1;
        win_pc  = '0;
        for (int unsigned k = 0; k < 6; k++) begin
            win_ins[k] = NOP_INSN;
        end
        if (win_v) begin
            win_len = npfx + 3'd1;
            win_pc  = q[head].pc;
            for (int unsigned k = 0; k < 6; k++) begin
                if (3'(k) <= npfx) win_ins[k] = slot[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            for (int unsigned i = 0; i < FETCH_W; i++) begin
                q[tail + PTR_W'(i)] <= '{ins: fetch_ins[i], pc: fetch_pc + ADDR_W'(i * INSN_BYTES)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(FETCH_W);
            head  <= head + adv[PTR_W-1:0];
            count <= count + (push ? CNT_W'(FETCH_W) : '0) - adv;
        end
    end

`ifdef QUPLS_REX_EN
    logic [3:0] regx_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            regx_r <= '0;
        else if (flush)
            regx_r <= '0;
        else if (head_kind == HEAD_ABSORB)
            regx_r <= slot[0][REX_LSB +: 4];
        else if (pop)
            regx_r <= '0;
    end

    assign regx = win_v ? regx_r : '0;
`else
    assign regx = '0;
`endif

endmodule

// File: tb/tb_qupls_ins_window.sv
// Self-checking bench for qupls_ins_window: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_qupls_ins_window;
    import qupls_ins_window_pkg::*;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned FETCH_W = 4;

    typedef instruction_t [FETCH_W-1:0] beat_t;
    typedef struct {
        instruction_t ins;
        address_t     pc;
    } ment_t;

    logic               clk, rst_n, flush, fetch_v, fetch_rdy, win_v, win_rdy;
    beat_t              fetch_ins;
    address_t           fetch_pc, win_pc;
    instruction_t [5:0] win_ins;
    logic [2:0]         win_len;
    logic [3:0]         regx;

    ment_t      mq[$];
    logic [3:0] mregx;
    int         checks, failures;

    qupls_ins_window #(.DEPTH(DEPTH), .FETCH_W(FETCH_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .fetch_v   (fetch_v),
        .fetch_rdy (fetch_rdy),
        .fetch_ins (fetch_ins),
        .fetch_pc  (fetch_pc),
        .win_v     (win_v),
        .win_rdy   (win_rdy),
        .win_ins   (win_ins),
        .win_pc    (win_pc),
        .win_len   (win_len),
        .regx      (regx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instruction_t mk(input logic [6:0] op);
        instruction_t v;
        v = {$urandom, $urandom};
        v[6:0] = op;
        return v;
    endfunction

    function automatic beat_t beat(input logic [6:0] o0, o1, o2, o3);
        beat_t b;
        b[0] = mk(o0);
        b[1] = mk(o1);
        b[2] = mk(o2);
        b[3] = mk(o3);
        return b;
    endfunction

    function automatic logic [6:0] rand_op();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r <= 2) return OP_PFX;
        if (r == 3) return OP_REX;
        if (r <= 5) return OP_ADD;
        if (r == 6) return OP_LDI;
        if (r == 7) return OP_SUB;
        return 7'($urandom);
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Window per the rules: head must be an ordinary instruction, then follow the run
    // of postfixes; the group is known only once a non-postfix follows or 5 are seen.
    task automatic model_view(output bit v, output int n);
        logic [6:0] hop;
        v = 1'b0;
        n = 0;
        if (mq.size() == 0) return;
        hop = mq[0].ins[6:0];
        if (hop == OP_PFX) return;
`ifdef QUPLS_REX_EN
        if (hop == OP_REX) return;
`endif
        while (n < 5 && (1 + n) < mq.size() && mq[1 + n].ins[6:0] == OP_PFX) n++;
        v = (n == 5) || ((1 + n) < mq.size());
    endtask

    task automatic compare();
        bit v;
        int n;
        instruction_t [5:0] ew;
        model_view(v, n);
        chk("win_v", win_v, v);
        chk("fetch_rdy", fetch_rdy, mq.size() <= int'(DEPTH - FETCH_W));
        if (v) begin
            for (int k = 0; k < 6; k++) ew[k] = (k <= n) ? mq[k].ins : NOP_INSN;
            chk("win_len", win_len, n + 1);
            chk("win_pc", win_pc, mq[0].pc);
            chk("win_ins", win_ins, ew);
`ifdef QUPLS_REX_EN
            chk("regx", regx, mregx);
`else
            chk("regx", regx, 4'd0);
`endif
        end
    endtask

    task automatic step(input logic fv, input beat_t b, input address_t pc,
                        input logic wr, input logic fl);
        bit v, rdy;
        int n;
        fetch_v = fv; fetch_ins = b; fetch_pc = pc; win_rdy = wr; flush = fl;
        model_view(v, n);
        rdy = (mq.size() <= int'(DEPTH - FETCH_W));
        if (fl) begin
            mq.delete();
            mregx = '0;
        end else begin
            if (v && wr) begin
                repeat (n + 1) void'(mq.pop_front());
                mregx = '0;
            end else if (mq.size() > 0 && mq[0].ins[6:0] == OP_PFX) begin
                void'(mq.pop_front());
`ifdef QUPLS_REX_EN
            end else if (mq.size() > 0 && mq[0].ins[6:0] == OP_REX) begin
                mregx = mq[0].ins[REX_LSB +: 4];
                void'(mq.pop_front());
`endif
            end
            if (fv && rdy)
                for (int i = 0; i < int'(FETCH_W); i++)
                    mq.push_back('{b[i], pc + address_t'(i * INSN_BYTES)});
        end
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input logic wr);
        step(1'b0, beat(OP_NOP, OP_NOP, OP_NOP, OP_NOP), '0, wr, 1'b0);
    endtask

    task automatic do_flush();
        step(1'b0, beat(OP_NOP, OP_NOP, OP_NOP, OP_NOP), '0, 1'b0, 1'b1);
    endtask

    initial begin
        instruction_t [5:0] nops;
        beat_t    b;
        address_t pc;
        checks = 0; failures = 0; mregx = '0;
        rst_n = 1'b0; flush = 1'b0; fetch_v = 1'b0; win_rdy = 1'b0;
        fetch_ins = '0; fetch_pc = '0;
        for (int k = 0; k < 6; k++) nops[k] = NOP_INSN;

        #12;
        chk("rst_win_v", win_v, 1'b0);
        chk("rst_fetch_rdy", fetch_rdy, 1'b1);
        chk("rst_win_len", win_len, 3'd1);
        chk("rst_win_pc", win_pc, 32'h0);
        chk("rst_regx", regx, 4'd0);
        chk("rst_win_ins", win_ins, nops);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain instructions: one window per cycle.
        step(1'b1, beat(OP_ADD, OP_ADD, OP_ADD, OP_ADD), 32'h100, 1'b1, 1'b0);
        chk("s1_pc0", win_pc, 32'h100);
        chk("s1_len0", win_len, 3'd1);
        step(1'b1, beat(OP_ADD, OP_ADD, OP_ADD, OP_ADD), 32'h114, 1'b1, 1'b0);
        chk("s1_pc1", win_pc, 32'h105);
        idle(1'b1);
        chk("s1_pc2", win_pc, 32'h10A);
        idle(1'b1);
        chk("s1_pc3", win_pc, 32'h10F);
        idle(1'b1);
        chk("s1_pc4", win_pc, 32'h114);
        do_flush();

        // Head with two postfixes.
        step(1'b1, beat(OP_LDI, OP_PFX, OP_PFX, OP_ADD), 32'h200, 1'b0, 1'b0);
        chk("s2_len", win_len, 3'd3);
        chk("s2_slot1", win_ins[1][6:0], OP_PFX);
        chk("s2_slot2", win_ins[2][6:0], OP_PFX);
        chk("s2_slot3", win_ins[3], NOP_INSN);
        chk("s2_slot5", win_ins[5], NOP_INSN);
        step(1'b1, beat(OP_ADD, OP_ADD, OP_ADD, OP_ADD), 32'h214, 1'b1, 1'b0);
        chk("s2_next_pc", win_pc, 32'h20F);
        chk("s2_next_len", win_len, 3'd1);
        do_flush();

        // Postfix run split across beats holds the head back.
        step(1'b1, beat(OP_SUB, OP_SUB, OP_LDI, OP_PFX), 32'h300, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("s3_hold0", win_v, 1'b0);
        idle(1'b1);
        chk("s3_hold1", win_v, 1'b0);
        idle(1'b1);
        chk("s3_hold2", win_v, 1'b0);
        step(1'b1, beat(OP_PFX, OP_PFX, OP_ADD, OP_ADD), 32'h314, 1'b1, 1'b0);
        chk("s3_v", win_v, 1'b1);
        chk("s3_len", win_len, 3'd4);
        chk("s3_pc", win_pc, 32'h30A);
        do_flush();

        // Fill to full, then concurrent push/pop with head wrap.
        pc = 32'h400;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, beat(OP_ADD, OP_ADD, OP_ADD, OP_ADD), pc, 1'b0, 1'b0);
            pc += 20;
            if (i == 2) chk("s4_rdy12", fetch_rdy, 1'b1);
        end
        chk("s4_rdy16", fetch_rdy, 1'b0);
        for (int i = 0; i < 24; i++) begin
            step(1'b1, beat(OP_ADD, OP_SUB, OP_ADD, OP_LDI), pc, 1'b1, 1'b0);
            pc += 20;
        end
        do_flush();

        // Flush beats a simultaneous fetch and pop.
        step(1'b1, beat(OP_ADD, OP_ADD, OP_ADD, OP_ADD), 32'h500, 1'b0, 1'b0);
        step(1'b1, beat(OP_ADD, OP_ADD, OP_ADD, OP_ADD), 32'h514, 1'b1, 1'b1);
        chk("s5_v", win_v, 1'b0);
        chk("s5_rdy", fetch_rdy, 1'b1);
        idle(1'b1);
        chk("s5_discard", win_v, 1'b0);

        // REX prefix.
        b = beat(OP_REX, OP_ADD, OP_ADD, OP_ADD);
        b[0][REX_LSB +: 4] = 4'b1010;
        step(1'b1, b, 32'h600, 1'b1, 1'b0);
`ifdef QUPLS_REX_EN
        chk("s6_absorb", win_v, 1'b0);
        idle(1'b1);
        chk("s6_v", win_v, 1'b1);
        chk("s6_regx", regx, 4'b1010);
        chk("s6_pc", win_pc, 32'h605);
        idle(1'b1);
        chk("s6_regx_clr", regx, 4'd0);
        chk("s6_pc2", win_pc, 32'h60A);
`else
        chk("s6_v", win_v, 1'b1);
        chk("s6_ins", win_ins[0], b[0]);
        chk("s6_regx", regx, 4'd0);
        idle(1'b1);
        chk("s6_pc2", win_pc, 32'h605);
`endif
        do_flush();

        // Random traffic.
        pc = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 60,
                 beat(rand_op(), rand_op(), rand_op(), rand_op()), pc,
                 $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 2);
            pc += 20;
        end

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, beat(OP_ADD, OP_PFX, OP_ADD, OP_SUB), pc, 1'b0, 1'b0);
            pc += 20;
        end
        fetch_v = 1'b0; win_rdy = 1'b0; flush = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_win_v", win_v, 1'b0);
        chk("arst_rdy", fetch_rdy, 1'b1);
        chk("arst_len", win_len, 3'd1);
        mq.delete();
        mregx = '0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        compare();
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 99) < 60,
                 beat(rand_op(), rand_op(), rand_op(), rand_op()), pc,
                 $urandom_range(0, 99) < 70, 1'b0);
            pc += 20;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
